// File: rtl/wb_regfile_if.sv
// Writeback slot and ID read-port bundle between the MEM/WB pipeline register,
// the decode stage and the register file.
interface wb_regfile_if #(
  parameter int unsigned XLEN = 32
);
  logic            WB_valid;
  logic            WB_rf_we;
  logic [1:0]      WB_rf_wsel;
  logic [4:0]      WB_wR;
  logic [XLEN-1:0] WB_pc4;
  logic [XLEN-1:0] WB_alu_c;
  logic [XLEN-1:0] WB_rd;
  logic [XLEN-1:0] WB_ext;
  logic [4:0]      rR1;
  logic [4:0]      rR2;
  logic [XLEN-1:0] rD1;
  logic [XLEN-1:0] rD2;
  logic [XLEN-1:0] wD;

  modport master (
    output WB_valid, WB_rf_we, WB_rf_wsel, WB_wR, WB_pc4, WB_alu_c, WB_rd, WB_ext,
    output rR1, rR2,
    input  rD1, rD2, wD
  );

  modport slave (
    input  WB_valid, WB_rf_we, WB_rf_wsel, WB_wR, WB_pc4, WB_alu_c, WB_rd, WB_ext,
    input  rR1, rR2,
    output rD1, rD2, wD
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback data select, 32-entry register file with write-through bypass and
// committed-write counter. Define DEBUG_TRACE_EN to build the registered commit trace.
module wb_regfile #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  wb_regfile_if.slave      bus,
  output logic [CNT_W-1:0] wb_cnt,
  output logic             debug_wb_have_inst,
  output logic [XLEN-1:0]  debug_wb_pc,
  output logic             debug_wb_ena,
  output logic [4:0]       debug_wb_reg,
  output logic [XLEN-1:0]  debug_wb_value
);

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] wd;
  logic            commit;

  // Writeback data select; also exported for hazard forwarding
  always_comb begin
    wd = bus.WB_alu_c;
    unique case (bus.WB_rf_wsel)
      2'b00: wd = bus.WB_alu_c;
      2'b01: wd = bus.WB_rd;
      2'b10: wd = bus.WB_ext;
      2'b11: wd = bus.WB_pc4;
    endcase
  end

  assign bus.wD = wd;

  // x0 and bubbles never commit; reset drops the in-flight write
  assign commit = !rst && bus.WB_valid && bus.WB_rf_we && (bus.WB_wR != 5'd0);

  // Read ports bypass the committing write so ID sees it with no extra latency
  assign bus.rD1 = (rst || bus.rR1 == 5'd0)         ? '0 :
                   (commit && bus.WB_wR == bus.rR1) ? wd : regs[bus.rR1];
  assign bus.rD2 = (rst || bus.rR2 == 5'd0)         ? '0 :
                   (commit && bus.WB_wR == bus.rR2) ? wd : regs[bus.rR2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (commit) begin
      regs[bus.WB_wR] <= wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wb_cnt <= '0;
    else if (commit) wb_cnt <= wb_cnt + CNT_W'(1);
  end

`ifdef DEBUG_TRACE_EN
  // One-cycle-late commit trace; bubbles report all-zero fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_wb_have_inst <= 1'b0;
      debug_wb_pc        <= '0;
      debug_wb_ena       <= 1'b0;
      debug_wb_reg       <= '0;
      debug_wb_value     <= '0;
    end else begin
      debug_wb_have_inst <= bus.WB_valid;
      debug_wb_pc        <= bus.WB_valid ? bus.WB_pc4 - XLEN'(4) : '0;
      debug_wb_ena       <= commit;
      debug_wb_reg       <= commit ? bus.WB_wR : 5'd0;
      debug_wb_value     <= commit ? wd : '0;
    end
  end
`else
  assign debug_wb_have_inst = 1'b0;
  assign debug_wb_pc        = '0;
  assign debug_wb_ena       = 1'b0;
  assign debug_wb_reg       = 5'd0;
  assign debug_wb_value     = '0;
`endif

endmodule
